// File: rtl/seg_display_sched.sv
// Display scheduler: shares one 2-digit seven-seg byte between N_SRC status sources,
// with dwell rotation, button advance and round-robin alert pre-emption. Optional blanking: SEG_SCHED_BLANK_EN.
module seg_display_sched #(
  parameter int N_SRC      = 4,
  parameter int DWELL_BITS = 24,
  parameter int HOLD_BITS  = 22
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [8*N_SRC-1:0]       src_data,
  input  logic                     auto_en,
  input  logic                     btn_next,
  input  logic [N_SRC-1:0]         alert_req,
  output logic [N_SRC-1:0]         alert_ack,
  output logic                     alert_active,
  output logic [$clog2(N_SRC)-1:0] disp_src,
  output logic [7:0]               disp_byte,
  output logic                     disp_blank
);

  localparam int IW = $clog2(N_SRC);

  typedef enum logic {ROTATE = 1'b0, ALERT = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         cur_q, cur_d, ret_q, ret_d, lg_q, lg_d;
  logic [IW-1:0]         cur_nxt, gnt_idx;
  logic                  gnt_vld;
  logic [DWELL_BITS-1:0] dwell_q, dwell_d;
  logic [HOLD_BITS-1:0]  hold_q, hold_d;
  logic [N_SRC-1:0]      ack_q, ack_d;
  logic                  active_q;
  logic [IW-1:0]         src_q;
  logic [7:0]            byte_q;
  logic                  blank_d;

  assign cur_nxt = (cur_q == IW'(N_SRC - 1)) ? '0 : cur_q + 1'b1;

  // Round-robin: first requester after the last grant, wrapping at N_SRC.
  always_comb begin
    logic [IW:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, lg_q} + (IW+1)'(1) + (IW+1)'(k);
      if (idx >= (IW+1)'(N_SRC)) idx = idx - (IW+1)'(N_SRC);
      if (!gnt_vld && alert_req[idx[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ret_d   = ret_q;
    lg_d    = lg_q;
    dwell_d = dwell_q;
    hold_d  = hold_q;
    ack_d   = '0;
    case (state_q)
      ROTATE: begin
        if (gnt_vld) begin
          ack_d[gnt_idx] = 1'b1;
          lg_d    = gnt_idx;
          ret_d   = cur_q;
          cur_d   = gnt_idx;
          hold_d  = '0;
          state_d = ALERT;
        end else if (btn_next || (auto_en && (&dwell_q))) begin
          cur_d   = cur_nxt;
          dwell_d = '0;
        end else if (auto_en) begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ALERT: begin
        hold_d = hold_q + 1'b1;
        if (btn_next || (&hold_q)) begin
          cur_d   = ret_q;
          dwell_d = '0;
          state_d = ROTATE;
        end
      end
      default: state_d = ROTATE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ROTATE;
      cur_q    <= '0;
      ret_q    <= '0;
      lg_q     <= IW'(N_SRC - 1);
      dwell_q  <= '0;
      hold_q   <= '0;
      ack_q    <= '0;
      active_q <= 1'b0;
      src_q    <= '0;
      byte_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      ret_q    <= ret_d;
      lg_q     <= lg_d;
      dwell_q  <= dwell_d;
      hold_q   <= hold_d;
      ack_q    <= ack_d;
      active_q <= (state_d == ALERT);
      src_q    <= cur_d;
      byte_q   <= blank_d ? 8'h00 : src_data[{cur_d, 3'b000} +: 8];
    end
  end

`ifdef SEG_SCHED_BLANK_EN
  logic [3:0] bcnt_q, bcnt_d;
  logic       blank_q;

  // Any source change (re)starts a 16-cycle dark gap.
  always_comb begin
    bcnt_d  = bcnt_q;
    blank_d = blank_q;
    if (cur_d != cur_q) begin
      blank_d = 1'b1;
      bcnt_d  = '0;
    end else if (blank_q) begin
      bcnt_d = bcnt_q + 1'b1;
      if (&bcnt_q) blank_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bcnt_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blank_q <= blank_d;
    end
  end

  assign disp_blank = blank_q;
`else
  assign blank_d    = 1'b0;
  assign disp_blank = 1'b0;
`endif

  assign alert_ack    = ack_q;
  assign alert_active = active_q;
  assign disp_src     = src_q;
  assign disp_byte    = byte_q;

endmodule

// File: tb/tb_seg_display_sched.sv
// Bench for seg_display_sched (N_SRC=3, DWELL_BITS=4, HOLD_BITS=3): per-cycle scoreboard
// from a behavioural model plus directed checks on the key scheduling points.
module tb_seg_display_sched;
  localparam int N  = 3;
  localparam int DW = 4;
  localparam int HB = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [23:0] src_data = {8'h56, 8'h34, 8'h12};
  logic        auto_en = 1'b0;
  logic        btn_next = 1'b0;
  logic [2:0]  alert_req = 3'b000;
  logic [2:0]  alert_ack;
  logic        alert_active;
  logic [1:0]  disp_src;
  logic [7:0]  disp_byte;
  logic        disp_blank;

  seg_display_sched #(.N_SRC(N), .DWELL_BITS(DW), .HOLD_BITS(HB)) dut (
    .CLK(CLK), .RST(RST), .src_data(src_data), .auto_en(auto_en), .btn_next(btn_next),
    .alert_req(alert_req), .alert_ack(alert_ack), .alert_active(alert_active),
    .disp_src(disp_src), .disp_byte(disp_byte), .disp_blank(disp_blank)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] src;
    logic [7:0] byt;
    logic [2:0] ack;
    logic       act;
    logic       blank;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  bit m_alert, m_bon;
  int m_cur, m_ret, m_lg, m_dwell, m_hold, m_bcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge using the inputs currently driven.
  task automatic model_step();
    exp_t        e;
    int          prev, gi;
    bit          found;
    logic [2:0]  sh;
    logic [23:0] sel;
    e.ack = 3'b000;
    if (RST) begin
      m_alert = 0; m_cur = 0; m_ret = 0; m_lg = N - 1;
      m_dwell = 0; m_hold = 0; m_bon = 0; m_bcnt = 0;
      e.src = 2'd0; e.byt = 8'h00; e.act = 1'b0; e.blank = 1'b0;
    end else begin
      prev = m_cur;
      if (!m_alert) begin
        if (alert_req != 3'b000) begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            gi = (m_lg + k) % N;
            sh = alert_req >> gi;
            if (!found && sh[0]) begin
              found = 1;
              m_lg  = gi;
            end
          end
          e.ack   = 3'(1 << m_lg);
          m_ret   = m_cur;
          m_cur   = m_lg;
          m_alert = 1;
          m_hold  = 0;
        end else if (btn_next || (auto_en && m_dwell == (1 << DW) - 1)) begin
          m_cur   = (m_cur + 1) % N;
          m_dwell = 0;
        end else if (auto_en) begin
          m_dwell++;
        end
      end else begin
        if (btn_next || m_hold == (1 << HB) - 1) begin
          m_cur   = m_ret;
          m_dwell = 0;
          m_alert = 0;
        end else begin
          m_hold++;
        end
      end
`ifdef SEG_SCHED_BLANK_EN
      if (m_cur != prev) begin
        m_bon = 1; m_bcnt = 0;
      end else if (m_bon) begin
        if (m_bcnt == 15) m_bon = 0;
        else m_bcnt++;
      end
`endif
      sel     = src_data >> (8 * m_cur);
      e.src   = 2'(m_cur);
      e.act   = m_alert;
      e.blank = m_bon;
      e.byt   = m_bon ? 8'h00 : sel[7:0];
    end
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("sb_src",   32'(disp_src),     32'(e.src));
    chk("sb_byte",  32'(disp_byte),    32'(e.byt));
    chk("sb_ack",   32'(alert_ack),    32'(e.ack));
    chk("sb_act",   32'(alert_active), 32'(e.act));
    chk("sb_blank", 32'(disp_blank),   32'(e.blank));
  endtask

  initial begin
    // Reset and live data tracking
    cycle(); cycle();
    chk("rst_src", 32'(disp_src), 0);
    chk("rst_ack", 32'(alert_ack), 0);
    chk("rst_act", 32'(alert_active), 0);
    chk("rst_byte", 32'(disp_byte), 0);
    RST = 1'b0;
    cycle();
    chk("rel_byte", 32'(disp_byte), 32'h12);
    src_data[7:0] = 8'h99;
    cycle();
    chk("live_byte", 32'(disp_byte), 32'h99);
    src_data[7:0] = 8'h12;
    cycle();

    // Auto rotation with wrap and hold-while-disabled
    auto_en = 1'b1;
    repeat (15) cycle();
    chk("auto_pre1", 32'(disp_src), 0);
    cycle();
    chk("auto_1", 32'(disp_src), 1);
    repeat (15) cycle();
    cycle();
    chk("auto_2", 32'(disp_src), 2);
    repeat (15) cycle();
    cycle();
    chk("auto_wrap", 32'(disp_src), 0);
    repeat (5) cycle();
    auto_en = 1'b0;
    repeat (30) cycle();
    chk("auto_frozen", 32'(disp_src), 0);
    auto_en = 1'b1;
    repeat (10) cycle();
    chk("dwell_held_pre", 32'(disp_src), 0);
    cycle();
    chk("dwell_held", 32'(disp_src), 1);

    // Button advance and dwell restart
    repeat (4) cycle();
    btn_next = 1'b1; cycle(); btn_next = 1'b0;
    chk("btn_adv", 32'(disp_src), 2);
    repeat (15) cycle();
    chk("btn_dwell_pre", 32'(disp_src), 2);
    cycle();
    chk("btn_dwell", 32'(disp_src), 0);
    repeat (15) cycle();
    btn_next = 1'b1; cycle(); btn_next = 1'b0;
    chk("btn_on_expiry", 32'(disp_src), 1);

    // Alert full hold window, then dwell restarted
    btn_next = 1'b1; cycle(); cycle(); btn_next = 1'b0;
    chk("pre_alert", 32'(disp_src), 0);
    cycle();
    alert_req = 3'b100; cycle(); alert_req = 3'b000;
    chk("al_ack", 32'(alert_ack), 32'h4);
    chk("al_src", 32'(disp_src), 2);
    chk("al_act", 32'(alert_active), 1);
    repeat (7) cycle();
    chk("al_hold_act", 32'(alert_active), 1);
    chk("al_hold_ack", 32'(alert_ack), 0);
    cycle();
    chk("al_ret_act", 32'(alert_active), 0);
    chk("al_ret_src", 32'(disp_src), 0);
    repeat (15) cycle();
    chk("al_dwell_pre", 32'(disp_src), 0);
    cycle();
    chk("al_dwell", 32'(disp_src), 1);

    // Alert cancelled by button at alert cycle 3
    auto_en = 1'b0;
    btn_next = 1'b1; cycle(); cycle(); btn_next = 1'b0;
    alert_req = 3'b100; cycle(); alert_req = 3'b000;
    chk("cx_ack", 32'(alert_ack), 32'h4);
    cycle(); cycle();
    btn_next = 1'b1; cycle(); btn_next = 1'b0;
    chk("cx_src", 32'(disp_src), 0);
    chk("cx_act", 32'(alert_active), 0);

    // Round-robin arbitration with a held pair of requests
    alert_req = 3'b001; cycle(); alert_req = 3'b000;
    chk("rr_set_ack", 32'(alert_ack), 32'h1);
    btn_next = 1'b1; cycle(); btn_next = 1'b0;
    alert_req = 3'b101; cycle();
    chk("rr_g1_ack", 32'(alert_ack), 32'h4);
    chk("rr_g1_src", 32'(disp_src), 2);
    repeat (7) cycle();
    cycle();
    chk("rr_gap_act", 32'(alert_active), 0);
    chk("rr_gap_ack", 32'(alert_ack), 0);
    chk("rr_gap_src", 32'(disp_src), 0);
    cycle();
    chk("rr_g2_ack", 32'(alert_ack), 32'h1);
    chk("rr_g2_act", 32'(alert_active), 1);
    alert_req = 3'b000;
    btn_next = 1'b1; cycle(); btn_next = 1'b0;

    // Alert beats button in the same cycle
    alert_req = 3'b100; btn_next = 1'b1; cycle(); alert_req = 3'b000; btn_next = 1'b0;
    chk("ab_ack", 32'(alert_ack), 32'h4);
    chk("ab_src", 32'(disp_src), 2);
    cycle();
    btn_next = 1'b1; cycle(); btn_next = 1'b0;
    chk("ab_ret_src", 32'(disp_src), 0);

    // Reset mid-alert
    alert_req = 3'b010; cycle(); alert_req = 3'b000;
    chk("rm_ack", 32'(alert_ack), 32'h2);
    cycle();
    RST = 1'b1; cycle();
    chk("rm_src", 32'(disp_src), 0);
    chk("rm_act", 32'(alert_active), 0);
    chk("rm_ack0", 32'(alert_ack), 0);
    RST = 1'b0; cycle();
    chk("rm_byte", 32'(disp_byte), 32'h12);

    // Blanking gap on source change
    btn_next = 1'b1; cycle(); btn_next = 1'b0;
    chk("bl_src", 32'(disp_src), 1);
`ifdef SEG_SCHED_BLANK_EN
    chk("bl_on", 32'(disp_blank), 1);
    chk("bl_byte0", 32'(disp_byte), 0);
    repeat (15) cycle();
    chk("bl_last", 32'(disp_blank), 1);
    cycle();
    chk("bl_off", 32'(disp_blank), 0);
    chk("bl_byte", 32'(disp_byte), 32'h34);
`else
    chk("bl_never", 32'(disp_blank), 0);
    chk("bl_byte", 32'(disp_byte), 32'h34);
`endif

    // Random mix against the model
    for (int i = 0; i < 400; i++) begin
      src_data  = 24'($urandom);
      if ($urandom_range(0, 15) == 0) auto_en = 1'($urandom_range(0, 1));
      btn_next  = ($urandom_range(0, 9) == 0);
      alert_req = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      RST       = ($urandom_range(0, 149) == 0);
      cycle();
    end
    RST = 1'b0; btn_next = 1'b0; alert_req = 3'b000;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
